// File: rtl/crc_stream_if.sv
// Serial bit-stream bundle between the packet layer, the CRC engine and the
// bit-stuffing/NRZI stages: per-packet controls, data bit, stalls and check result.
interface crc_stream_if;
  logic mode;
  logic start;
  logic pkttype;
  logic inb;
  logic recving;
  logic pause_out;
  logic outb;
  logic sending;
  logic pause_in;
  logic crc_valid;
  logic crc_ok;

  modport master (
    output mode, start, pkttype, inb, recving, pause_out,
    input  outb, sending, pause_in, crc_valid, crc_ok
  );

  modport slave (
    input  mode, start, pkttype, inb, recving, pause_out,
    output outb, sending, pause_in, crc_valid, crc_ok
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Serial CRC engine with two selectable profiles: passes the packet through and
// either appends the inverted CRC (generate) or compares against the residual (check).
module crc_stream_engine #(
  parameter int              W_S     = 5,
  parameter logic [W_S-1:0]  POLY_S  = 5'h05,
  parameter logic [W_S-1:0]  RESID_S = 5'h0C,
  parameter int              W_L     = 16,
  parameter logic [W_L-1:0]  POLY_L  = 16'h8005,
  parameter logic [W_L-1:0]  RESID_L = 16'h800D
) (
  input  logic clk,
  input  logic rst_L,
  crc_stream_if.slave bus
);

  localparam int CNT_W = (W_L > 1) ? $clog2(W_L) : 1;
  localparam logic [W_L-1:0]   MASK_L   = '1;
  localparam logic [W_L-1:0]   MASK_S   = MASK_L >> (W_L - W_S);
  localparam logic [W_L-1:0]   POLY_SX  = W_L'(POLY_S);
  localparam logic [W_L-1:0]   RESID_SX = W_L'(RESID_S);
  localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(W_S - 1);
  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(W_L - 1);

  typedef enum logic [1:0] {IDLE, CALC, APPEND} state_t;

  state_t           state_q, state_d;
  logic [W_L-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             type_q, type_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] bit_idx;
  logic             app_bit;

  function automatic logic [W_L-1:0] prof_mask(input logic t);
    return t ? MASK_L : MASK_S;
  endfunction

  // One serial CRC step; bits above the active profile width stay zero.
  function automatic logic [W_L-1:0] crc_shift(input logic [W_L-1:0] r,
                                               input logic b, input logic t);
    logic fb;
    fb = b ^ (t ? r[W_L-1] : r[W_S-1]);
    return ((r << 1) & prof_mask(t)) ^ (fb ? (t ? POLY_L : POLY_SX) : '0);
  endfunction

  // CRC is emitted MSB first, inverted.
  assign last_idx = type_q ? LAST_L : LAST_S;
  assign bit_idx  = last_idx - cnt_q;
  assign app_bit  = ~crc_q[bit_idx];

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      crc_q   <= '1;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      type_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      type_q  <= type_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    type_d        = type_q;
    ok_d          = ok_q;
    bus.outb      = bus.inb;
    bus.sending   = 1'b0;
    bus.pause_in  = 1'b0;
    bus.crc_valid = 1'b0;
    bus.crc_ok    = ok_q;

    unique case (state_q)
      IDLE: begin
        // The marker bit passes through but is not part of the CRC.
        if (bus.start && bus.recving) begin
          state_d     = CALC;
          crc_d       = prof_mask(bus.pkttype);
          mode_d      = bus.mode;
          type_d      = bus.pkttype;
          ok_d        = 1'b0;
          bus.sending = 1'b1;
        end
      end

      CALC: begin
        if (bus.recving) begin
          bus.sending  = 1'b1;
          bus.pause_in = bus.pause_out;
          if (!bus.pause_out) crc_d = crc_shift(crc_q, bus.inb, type_q);
        end else if (!mode_q) begin
          // First CRC bit goes out in the same cycle the payload ends.
          bus.sending  = 1'b1;
          bus.pause_in = 1'b1;
          bus.outb     = app_bit;
          if (!bus.pause_out) cnt_d = cnt_q + CNT_W'(1);
          state_d = APPEND;
        end else begin
          bus.crc_valid = 1'b1;
          ok_d          = (crc_q == (type_q ? RESID_L : RESID_SX));
          bus.crc_ok    = ok_d;
          state_d       = IDLE;
        end
      end

      APPEND: begin
        bus.sending  = 1'b1;
        bus.pause_in = 1'b1;
        bus.outb     = app_bit;
        if (!bus.pause_out) begin
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: drivers queue the expected per-cycle
// output bits and check results, a negedge monitor pops and compares them.
module tb_crc_stream_engine;
  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  crc_stream_if bus();

  crc_stream_engine #(
    .W_S(5), .POLY_S(5'h05), .RESID_S(5'h0C),
    .W_L(16), .POLY_L(16'h8005), .RESID_L(16'h800D)
  ) dut (
    .clk(clk),
    .rst_L(rst_L),
    .bus(bus)
  );

  typedef struct packed {
    logic outb;
    logic pause_in;
  } exp_t;

  exp_t exp_q[$];
  logic ok_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC, MSB of d[n-1:0] first, init all ones.
  function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                            input int n, input logic [63:0] d);
    logic [31:0] mask;
    logic [31:0] r;
    logic        fb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = mask;
    for (int i = 0; i < n; i++) begin
      fb = d[n-1-i] ^ r[w-1];
      r  = ((r << 1) & mask) ^ (fb ? poly : 32'd0);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_L) begin
      if (bus.sending) begin
        if (exp_q.size() == 0) chk_bit("unexpected_send", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk_bit("outb", bus.outb, e.outb);
          chk_bit("pause_in", bus.pause_in, e.pause_in);
        end
      end
      if (bus.crc_valid) begin
        if (ok_q.size() == 0) chk_bit("unexpected_crc_valid", 1'b1, 1'b0);
        else chk_bit("crc_ok", bus.crc_ok, ok_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic o, input logic p);
    exp_t e;
    e.outb = o;
    e.pause_in = p;
    exp_q.push_back(e);
  endtask

  // Generate-mode packet; optional stall on CRC bit stall_at and stray start pulses.
  task automatic gen_pkt(input logic t, input logic sbit, input int n,
                         input logic [63:0] d, input logic [31:0] crc,
                         input int stall_at, input int stall_len, input int poke);
    int w;
    w = t ? 16 : 5;
    bus.mode = 1'b0; bus.pkttype = t; bus.start = 1'b1; bus.recving = 1'b1;
    bus.inb = sbit; bus.pause_out = 1'b0;
    push(sbit, 1'b0);
    step();
    bus.mode = 1'b1; bus.pkttype = ~t;
    for (int i = 0; i < n; i++) begin
      bus.start = (i == poke);
      bus.inb = d[n-1-i];
      push(d[n-1-i], 1'b0);
      step();
    end
    bus.start = 1'b0; bus.recving = 1'b0; bus.inb = 1'b1;
    for (int j = 0; j < w; j++) begin
      bus.start = (poke >= 0) && (j == 2);
      if (j == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.pause_out = 1'b1;
          push(~crc[w-1-j], 1'b1);
          step();
        end
      end
      bus.pause_out = 1'b0;
      push(~crc[w-1-j], 1'b1);
      step();
    end
    bus.start = 1'b0;
    chk_bit("gen_sending_end", bus.sending, 1'b0);
    chk_int("gen_drain", exp_q.size(), 0);
  endtask

  task automatic chk_pkt(input logic t, input logic sbit, input int n,
                         input logic [63:0] d, input logic exp_ok);
    bus.mode = 1'b1; bus.pkttype = t; bus.start = 1'b1; bus.recving = 1'b1;
    bus.inb = sbit; bus.pause_out = 1'b0;
    push(sbit, 1'b0);
    step();
    bus.start = 1'b0; bus.mode = 1'b0; bus.pkttype = ~t;
    for (int i = 0; i < n; i++) begin
      bus.inb = d[n-1-i];
      push(d[n-1-i], 1'b0);
      step();
    end
    bus.recving = 1'b0; bus.inb = 1'b0;
    ok_q.push_back(exp_ok);
    step();
    chk_int("crc_valid_seen", ok_q.size(), 0);
    chk_bit("crc_ok_hold", bus.crc_ok, exp_ok);
    chk_bit("chk_sending_end", bus.sending, 1'b0);
    chk_int("chk_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] crc_l;
    logic [63:0] d;
    bus.mode = 1'b0; bus.start = 1'b0; bus.pkttype = 1'b0; bus.inb = 1'b0;
    bus.recving = 1'b0; bus.pause_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.inb = 1'b1;
    #1;
    chk_bit("rst_outb", bus.outb, 1'b1);
    chk_bit("rst_sending", bus.sending, 1'b0);
    chk_bit("rst_pause_in", bus.pause_in, 1'b0);
    chk_bit("rst_crc_valid", bus.crc_valid, 1'b0);
    chk_bit("rst_crc_ok", bus.crc_ok, 1'b0);
    rst_L = 1'b1;
    step();
    bus.inb = 1'b0;
    #1 chk_bit("idle_outb", bus.outb, 1'b0);
    step();

    // Short generate: 11 zero bits -> reg 10111, appended 0,1,0,0,0.
    gen_pkt(1'b0, 1'b1, 11, 64'd0, 32'h17, -1, 0, -1);
    // Long generate, zero payload -> 16 zero CRC bits.
    gen_pkt(1'b1, 1'b0, 0, 64'd0, 32'hFFFF, -1, 0, -1);
    // Short check good, then payload bit 3 flipped.
    chk_pkt(1'b0, 1'b1, 16, 64'h0008, 1'b1);
    chk_pkt(1'b0, 1'b1, 16, 64'h1008, 1'b0);

    crc_l = crc_model(16, 32'h8005, 16, 64'hA5C3);
    gen_pkt(1'b1, 1'b1, 16, 64'hA5C3, crc_l, -1, 0, -1);
    d = {32'd0, 16'hA5C3, ~crc_l[15:0]};
    chk_pkt(1'b1, 1'b0, 32, d, 1'b1);

    // Asynchronous reset clears the held check result immediately.
    #2 rst_L = 1'b0;
    #1 chk_bit("async_rst_crc_ok", bus.crc_ok, 1'b0);
    step();
    rst_L = 1'b1;
    step();

    // Stall on CRC bit 7 for 3 cycles.
    gen_pkt(1'b1, 1'b1, 16, 64'hA5C3, crc_l, 7, 3, -1);
    // Stray start pulses during CALC and APPEND.
    gen_pkt(1'b0, 1'b0, 11, 64'd0, 32'h17, -1, 0, 5);

    // Start with recving low is ignored.
    bus.start = 1'b1; bus.recving = 1'b0;
    #1 chk_bit("start_norecv_send", bus.sending, 1'b0);
    step();
    bus.start = 1'b0;
    chk_bit("start_norecv_after", bus.sending, 1'b0);
    step();

    // Reset while APPEND is at cnt=4.
    bus.mode = 1'b0; bus.pkttype = 1'b0; bus.start = 1'b1; bus.recving = 1'b1; bus.inb = 1'b1;
    push(1'b1, 1'b0);
    step();
    bus.start = 1'b0; bus.inb = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push(1'b0, 1'b0);
      step();
    end
    bus.recving = 1'b0; bus.inb = 1'b1;
    push(1'b0, 1'b1); push(1'b1, 1'b1); push(1'b0, 1'b1); push(1'b0, 1'b1);
    repeat (4) step();
    #1 rst_L = 1'b0;
    #1;
    chk_bit("midrst_sending", bus.sending, 1'b0);
    chk_bit("midrst_pause_in", bus.pause_in, 1'b0);
    chk_bit("midrst_crc_valid", bus.crc_valid, 1'b0);
    chk_bit("midrst_outb", bus.outb, 1'b1);
    chk_int("midrst_drain", exp_q.size(), 0);
    step();
    step();
    rst_L = 1'b1;
    step();
    chk_bit("postrst_sending", bus.sending, 1'b0);
    gen_pkt(1'b0, 1'b1, 11, 64'd0, 32'h17, -1, 0, -1);

    step();
    chk_int("final_exp_drain", exp_q.size(), 0);
    chk_int("final_ok_drain", ok_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
